// File: rtl/iddmm_pkg.sv
// rtl/iddmm_pkg.sv - shared operand geometry and packer FSM states for the IDDMM datapath
package iddmm_pkg;

    localparam int K_DEF = 128;
    localparam int N_DEF = 16;
    localparam int W_DEF = 32;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_START,
        ST_GAP,
        ST_SEND,
        ST_WAIT_RES
    } packer_state_t;

endpackage

// File: rtl/me_x_packer_if.sv
// rtl/me_x_packer_if.sv - plaintext chunk stream in, operand words and core handshake out
interface me_x_packer_if
    import iddmm_pkg::*;
#(
    parameter int K = K_DEF,
    parameter int W = W_DEF
);
    logic [W-1:0] s_data;
    logic         s_valid;
    logic         s_last;
    logic         s_ready;
    logic         me_start;
    logic [K-1:0] me_x;
    logic         me_x_valid;
    logic         me_valid;
    logic         busy;
    logic         blk_done;

    modport slave (
        input  s_data, s_valid, s_last, me_valid,
        output s_ready, me_start, me_x, me_x_valid, busy, blk_done
    );

    modport master (
        output s_data, s_valid, s_last, me_valid,
        input  s_ready, me_start, me_x, me_x_valid, busy, blk_done
    );
endinterface

// File: rtl/x_word_buf.sv
// rtl/x_word_buf.sv - N x K operand buffer, one W-bit lane write port, one read port, per-word valid flags
module x_word_buf #(
    parameter int K  = 128,
    parameter int N  = 16,
    parameter int W  = 32,
    parameter int LA = 2,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_word,
    input  logic [LA-1:0] i_wr_lane,
    input  logic [W-1:0]  i_wr_data,
    input  logic          i_rd_clr,
    input  logic [AW-1:0] i_rd_word,
    output logic [K-1:0]  o_rd_data
);
    localparam int LANES = K / W;

    logic [K-1:0] r_mem [N];
    logic [N-1:0] r_vld;

    // First write into an invalid word zeroes its other lanes, so stale data never resurfaces.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                if (LA'(l) == i_wr_lane)
                    r_mem[i_wr_word][l*W +: W] <= i_wr_data;
                else if (!r_vld[i_wr_word])
                    r_mem[i_wr_word][l*W +: W] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            if (i_rd_clr)
                r_vld[i_rd_word] <= 1'b0;
            if (i_wr_en)
                r_vld[i_wr_word] <= 1'b1;
        end
    end

    assign o_rd_data = r_vld[i_rd_word] ? r_mem[i_rd_word] : '0;

endmodule

// File: rtl/me_x_packer.sv
// rtl/me_x_packer.sv - packs W-bit chunks into N K-bit operand words and feeds the exponentiation core
module me_x_packer
    import iddmm_pkg::*;
#(
    parameter int K = K_DEF,
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    me_x_packer_if.slave  bus
);
    localparam int LANES = K / W;
    localparam int CW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int WW    = $clog2(N) + 1;
    localparam int AW    = (N > 1) ? $clog2(N) : 1;

    packer_state_t r_state, w_next;
    logic [CW-1:0] r_chunk;
    logic [WW-1:0] r_word;
    logic [WW-1:0] r_res;

    logic         w_accept, w_last_pos, w_close, w_send_end, w_res_end;
    logic [K-1:0] w_rd_data;

    assign w_accept   = (r_state == ST_FILL) && bus.s_valid;
    assign w_last_pos = (r_chunk == CW'(LANES - 1)) && (r_word == WW'(N - 1));
    assign w_close    = w_accept && (bus.s_last || w_last_pos);
    assign w_send_end = (r_state == ST_SEND) && (r_word == WW'(N - 1));
    assign w_res_end  = (r_state == ST_WAIT_RES) && bus.me_valid && (r_res == WW'(N - 1));

    always_comb begin
        w_next         = r_state;
        bus.s_ready    = 1'b0;
        bus.me_start   = 1'b0;
        bus.me_x_valid = 1'b0;
        bus.busy       = 1'b1;
        bus.blk_done   = 1'b0;
        case (r_state)
            ST_FILL: begin
                bus.s_ready = 1'b1;
                bus.busy    = 1'b0;
                if (w_close)
                    w_next = ST_START;
            end
            ST_START: begin
                bus.me_start = 1'b1;
                w_next       = ST_GAP;
            end
            ST_GAP: w_next = ST_SEND;
            ST_SEND: begin
                bus.me_x_valid = 1'b1;
                if (w_send_end)
                    w_next = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                bus.blk_done = w_res_end;
                if (w_res_end)
                    w_next = ST_FILL;
            end
            default: w_next = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
            r_chunk <= '0;
            r_word  <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_FILL: begin
                    if (w_close) begin
                        r_chunk <= '0;
                        r_word  <= '0;
                    end else if (w_accept) begin
                        if (r_chunk == CW'(LANES - 1)) begin
                            r_chunk <= '0;
                            r_word  <= r_word + 1'b1;
                        end else begin
                            r_chunk <= r_chunk + 1'b1;
                        end
                    end
                end
                ST_SEND: r_word <= w_send_end ? '0 : r_word + 1'b1;
                ST_WAIT_RES: begin
                    if (bus.me_valid)
                        r_res <= (r_res == WW'(N - 1)) ? '0 : r_res + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Reading a word during SEND drops its valid flag, leaving the buffer blank for the next block.
    x_word_buf #(
        .K (K),
        .N (N),
        .W (W),
        .LA(CW),
        .AW(AW)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .i_wr_en  (w_accept),
        .i_wr_word(r_word[AW-1:0]),
        .i_wr_lane(r_chunk),
        .i_wr_data(bus.s_data),
        .i_rd_clr (r_state == ST_SEND),
        .i_rd_word(r_word[AW-1:0]),
        .o_rd_data(w_rd_data)
    );

    assign bus.me_x = (r_state == ST_SEND) ? w_rd_data : '0;

endmodule

// File: tb/tb_me_x_packer.sv
// tb/tb_me_x_packer.sv - directed self-checking bench for me_x_packer
module tb_me_x_packer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    me_x_packer_if #(.K(128), .W(32)) bus ();

    me_x_packer #(.K(128), .N(16), .W(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [127:0] got_w [16];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] seq_word(input int base);
        logic [31:0] b;
        b = 32'(base);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    task automatic push(input logic [31:0] d, input logic last);
        int n;
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        bus.s_last  = last;
        #1;
        n = 0;
        while (!bus.s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100)
            check("push_timeout", 128'(bus.s_ready), 128'd1);
        @(negedge clk);
    endtask

    task automatic idle_src();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_data  = '0;
    endtask

    // Entered in the START cycle; walks GAP, SEND and the first WAIT_RES cycle.
    task automatic get_words(input string tag);
        int nv;
        @(negedge clk);
        check({tag, "_gap_valid"}, 128'(bus.me_x_valid), 128'd0);
        nv = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            got_w[k] = bus.me_x;
            if (bus.me_x_valid) nv++;
        end
        check({tag, "_nvalid"}, 128'(nv), 128'd16);
        @(negedge clk);
        check({tag, "_after_send_valid"}, 128'(bus.me_x_valid), 128'd0);
    endtask

    task automatic pulse(output logic done);
        bus.me_valid = 1'b1;
        #1;
        done = bus.blk_done;
        @(negedge clk);
        bus.me_valid = 1'b0;
    endtask

    task automatic finish_block(input string tag);
        logic d;
        logic any_d;
        any_d = 1'b0;
        for (int p = 0; p < 15; p++) begin
            pulse(d);
            any_d |= d;
        end
        check({tag, "_early_done"}, 128'(any_d), 128'd0);
        check({tag, "_busy_15"}, 128'(bus.busy), 128'd1);
        pulse(d);
        check({tag, "_done_16"}, 128'(d), 128'd1);
        #1;
        check({tag, "_ready_after"}, 128'(bus.s_ready), 128'd1);
    endtask

    task automatic full_block(input string tag, input int base);
        for (int i = 1; i <= 64; i++)
            push(32'(base + i), 1'b0);
        idle_src();
        check({tag, "_start"}, 128'(bus.me_start), 128'd1);
        check({tag, "_ready_low"}, 128'(bus.s_ready), 128'd0);
        get_words(tag);
        for (int k = 0; k < 16; k++)
            check({tag, "_word"}, got_w[k], seq_word(base + 4*k + 1));
    endtask

    logic d0;
    logic any_start;
    logic [127:0] rest_or;

    initial begin
        rst = 1'b1;
        bus.s_data = '0; bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.me_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 128'(bus.s_ready), 128'd1);
        check("rst_start", 128'(bus.me_start), 128'd0);
        check("rst_xvalid", 128'(bus.me_x_valid), 128'd0);
        check("rst_x", bus.me_x, 128'd0);
        check("rst_busy", 128'(bus.busy), 128'd0);
        check("rst_done", 128'(bus.blk_done), 128'd0);
        rst = 1'b0;

        // Full block of 64 sequential chunks
        full_block("full", 0);
        check("full_w0", got_w[0], 128'h00000004_00000003_00000002_00000001);
        check("full_w15", got_w[15], 128'h00000040_0000003F_0000003E_0000003D);

        // Back-pressure: chunk offered during WAIT_RES waits for the next FILL
        bus.s_data = 32'h55; bus.s_valid = 1'b1; bus.s_last = 1'b1;
        #1;
        check("bp_ready_wait", 128'(bus.s_ready), 128'd0);
        finish_block("full");
        @(negedge clk);
        idle_src();
        check("bp_start", 128'(bus.me_start), 128'd1);
        get_words("bp");
        check("bp_w0", got_w[0], 128'h55);
        rest_or = '0;
        for (int k = 1; k < 16; k++) rest_or |= got_w[k];
        check("bp_rest_zero", rest_or, 128'd0);
        finish_block("bp");

        // Early last after five chunks
        for (int i = 0; i < 5; i++)
            push(32'hAAAAAAAA, i == 4);
        idle_src();
        check("early_start", 128'(bus.me_start), 128'd1);
        get_words("early");
        check("early_w0", got_w[0], {4{32'hAAAAAAAA}});
        check("early_w1", got_w[1], 128'h00000000_00000000_00000000_AAAAAAAA);
        rest_or = '0;
        for (int k = 2; k < 16; k++) rest_or |= got_w[k];
        check("early_rest_zero", rest_or, 128'd0);
        finish_block("early");

        // Reset during SEND after seven words
        for (int i = 1; i <= 64; i++)
            push(32'(32'h100 + i), 1'b0);
        idle_src();
        check("rs_start", 128'(bus.me_start), 128'd1);
        @(negedge clk);
        for (int k = 0; k < 7; k++) @(negedge clk);
        check("rs_sending", 128'(bus.me_x_valid), 128'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rs_xvalid", 128'(bus.me_x_valid), 128'd0);
        check("rs_x", bus.me_x, 128'd0);
        check("rs_busy", 128'(bus.busy), 128'd0);
        any_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            any_start |= bus.me_start | bus.me_x_valid;
        end
        check("rs_no_start", 128'(any_start), 128'd0);
        full_block("post_rst", 32'h200);
        finish_block("post_rst");

        // Stray me_valid in FILL is ignored; next block still needs 16 results
        d0 = 1'b0;
        for (int p = 0; p < 3; p++) begin
            logic d;
            pulse(d);
            d0 |= d;
        end
        check("stray_done", 128'(d0), 128'd0);
        push(32'h12345678, 1'b1);
        idle_src();
        check("stray_start", 128'(bus.me_start), 128'd1);
        get_words("stray");
        check("stray_w0", got_w[0], 128'h12345678);
        rest_or = '0;
        for (int k = 1; k < 16; k++) rest_or |= got_w[k];
        check("stray_rest_zero", rest_or, 128'd0);
        finish_block("stray");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/me_x_packer.md
ME_X_PACKER -- requirements
Module: me_x_packer

Interface
REQ-001 Parameter K, default 128, bits per operand word; SHALL be a multiple of W.
REQ-002 Parameter N, default 16, operand words per 2048-bit block.
REQ-003 Parameter W, default 32, input stream width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 s_data  input  W  plaintext chunk; least-significant chunk of the block first.
REQ-007 s_valid  input  1  s_data valid.
REQ-008 s_last  input  1  final chunk of a message; qualified by s_valid.
REQ-009 s_ready  output  1  packer accepts a chunk this cycle.
REQ-010 me_start  output  1  one-cycle start pulse to the exponentiation core.
REQ-011 me_x  output  K  operand word, low word first.
REQ-012 me_x_valid  output  1  me_x valid.
REQ-013 me_valid  input  1  result-word strobe from the core, N pulses per block.
REQ-014 busy  output  1  high in every state except FILL.
REQ-015 blk_done  output  1  one-cycle pulse after the N-th me_valid of a block.

Function
REQ-016 The FSM SHALL have the states FILL, START, GAP, SEND and WAIT_RES.
REQ-017 FILL: s_ready=1; a chunk is accepted when s_valid&s_ready.
  - Accepted chunk written to bits [c*W +: W] of word w of an N x K buffer.
  - c counts 0..K/W-1; w counts 0..N-1.
REQ-018 Block closure SHALL occur when the (N*K/W)-th chunk is accepted, or when a chunk with s_last=1 is accepted, whichever is first.
REQ-019 s_last on the final chunk position SHALL be ignored beyond closure.
REQ-020 On early closure by s_last, all unwritten chunk positions of the block SHALL read as zero.
  - Achieved by clearing the buffer while sending, not by a multi-cycle clear.
REQ-021 FILL to START on closure.
  - Chunk counter and word counter reset to 0.
  - s_ready=0 from the next cycle.
REQ-022 START lasts one cycle with me_start=1, then GAP.
REQ-023 GAP lasts one cycle with me_x_valid=0, then SEND.
REQ-024 SEND SHALL drive me_x_valid=1 for exactly N consecutive cycles.
  - me_x = buffer word 0..N-1 in order.
  - Each word is zeroed after it is read.
REQ-025 After the N-th word, the FSM goes to WAIT_RES.
REQ-026 WAIT_RES SHALL count me_valid pulses modulo N.
  - On the N-th pulse: blk_done=1 for one cycle, then FILL.
REQ-027 me_valid outside WAIT_RES SHALL be ignored.
REQ-028 s_valid while s_ready=0 SHALL NOT be consumed; the source holds its data.
REQ-029 Latency: the me_start cycle is the cycle after the closing handshake; the first me_x_valid is 2 cycles after me_start.
REQ-030 Counter widths: chunk counter $clog2(K/W), word counter $clog2(N)+1, result counter $clog2(N)+1; no wrap except as stated.

Reset
REQ-031 On rst=1 at a clock edge, the state SHALL become FILL and all counters SHALL clear.
  - Outputs: s_ready=1, me_start=0, me_x_valid=0, me_x=0, busy=0, blk_done=0.
REQ-032 The buffer SHALL be zeroed by reset.
  - Either a reset-time clear, or a valid-per-word flag that forces zero read data for unwritten words.
REQ-033 Reset mid-block (any state) SHALL abandon the block: no further me_start or me_x_valid until a new block closes.

Structure
REQ-034 K, N, W defaults and the FSM state enum SHALL reside in shared package iddmm_pkg, reused by result-side blocks.
REQ-035 The N x K buffer SHALL be one sub-module, x_word_buf: 1 write port with W-bit lane enable, 1 read port, per-word valid flags.
REQ-036 The target size is 150-300 lines of RTL, with no multipliers.

Verification
REQ-037 Full block: 64 chunks 0x00000001..0x00000040, s_valid held high.
  - me_start in the cycle after chunk 64.
  - me_x word0 = 0x00000004_00000003_00000002_00000001.
  - me_x word15 = 0x00000040_0000003F_0000003E_0000003D.
  - 16 consecutive valids.
REQ-038 Early last: 5 chunks 0xAAAAAAAA with s_last on the 5th.
  - word0 = all-A.
  - word1 = 0x00000000_00000000_00000000_AAAAAAAA.
  - words 2..15 = 0.
REQ-039 Back-pressure: s_valid during SEND/WAIT_RES -> s_ready=0 and the chunk is not consumed; it is accepted in the first FILL cycle after blk_done.
REQ-040 Result gating: 15 me_valid pulses -> no blk_done and busy=1; the 16th pulse -> blk_done pulse and s_ready=1 the next cycle.
REQ-041 Reset during SEND after 7 words -> me_x_valid=0 the next cycle; a following 64-chunk block produces correct words with no residue from the previous block.
REQ-042 Stray me_valid in FILL -> ignored; the next block still needs 16 pulses.
